// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter_if
// Description : Request/response bundle between two operand-fetch requesters,
//               the round-robin arbiter and the shared ALU stage.
//               master = requesters/ALU side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2,
  parameter int CNT_W  = 16
);
  // Requester 0
  logic              v_i0;
  logic [DATA_W-1:0] a_i0;
  logic [DATA_W-1:0] b_i0;
  logic [OP_W-1:0]   op_i0;
  logic              stall_o0;
  // Requester 1
  logic              v_i1;
  logic [DATA_W-1:0] a_i1;
  logic [DATA_W-1:0] b_i1;
  logic [OP_W-1:0]   op_i1;
  logic              stall_o1;
  // Output stage towards the ALU
  logic              v_o;
  logic [DATA_W-1:0] data_o1;
  logic [DATA_W-1:0] data_o2;
  logic [OP_W-1:0]   opcode_o;
  logic              tag_o;
  logic              stall_i;
  // Grant statistics
  logic [CNT_W-1:0]  gnt_cnt0;
  logic [CNT_W-1:0]  gnt_cnt1;

  modport master (
    output v_i0, a_i0, b_i0, op_i0,
    input  stall_o0,
    output v_i1, a_i1, b_i1, op_i1,
    input  stall_o1,
    input  v_o, data_o1, data_o2, opcode_o, tag_o,
    output stall_i,
    input  gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  v_i0, a_i0, b_i0, op_i0,
    output stall_o0,
    input  v_i1, a_i1, b_i1, op_i1,
    output stall_o1,
    output v_o, data_o1, data_o2, opcode_o, tag_o,
    input  stall_i,
    output gnt_cnt0, gnt_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Two-requester round-robin arbiter feeding a one-entry output
//               register stage in front of the shared ALU. The winning
//               operand pair/opcode is registered together with the ID of
//               the requester that supplied it.
//               Optional feature macro: ALU_ARB_STATS_EN (saturating
//               per-requester grant counters; tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_rr_arbiter_if.slave    bus
);

  logic              r_v_o;
  logic [DATA_W-1:0] r_data_o1;
  logic [DATA_W-1:0] r_data_o2;
  logic [OP_W-1:0]   r_opcode_o;
  logic              r_tag_o;
  logic              r_last_gnt;

  logic              w_ld;
  logic              w_gnt0;
  logic              w_gnt1;

  // The output stage can take a new entry when empty or being drained this
  // cycle. On contention the requester that did not win last time gets it.
  always_comb begin
    w_ld   = !r_v_o || !bus.stall_i;
    w_gnt0 = bus.v_i0 && (!bus.v_i1 || r_last_gnt);
    w_gnt1 = bus.v_i1 && (!bus.v_i0 || !r_last_gnt);
  end

  // Requesters are held unless they win a load; no grants during reset.
  assign bus.stall_o0 = reset || !(w_ld && w_gnt0);
  assign bus.stall_o1 = reset || !(w_ld && w_gnt1);

  // Output stage: load the winner, empty on an ungranted load, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v_o      <= 1'b0;
      r_data_o1  <= '0;
      r_data_o2  <= '0;
      r_opcode_o <= '0;
      r_tag_o    <= 1'b0;
      r_last_gnt <= 1'b1;
    end else if (w_ld) begin
      if (w_gnt0 || w_gnt1) begin
        r_v_o      <= 1'b1;
        r_data_o1  <= w_gnt1 ? bus.a_i1  : bus.a_i0;
        r_data_o2  <= w_gnt1 ? bus.b_i1  : bus.b_i0;
        r_opcode_o <= w_gnt1 ? bus.op_i1 : bus.op_i0;
        r_tag_o    <= w_gnt1;
        r_last_gnt <= w_gnt1;
      end else begin
        r_v_o <= 1'b0;
      end
    end
  end

  assign bus.v_o      = r_v_o;
  assign bus.data_o1  = r_data_o1;
  assign bus.data_o2  = r_data_o2;
  assign bus.opcode_o = r_opcode_o;
  assign bus.tag_o    = r_tag_o;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_gnt_cnt0;
  logic [CNT_W-1:0] r_gnt_cnt1;

  // Per-requester grant counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_ld && w_gnt0 && (r_gnt_cnt0 != {CNT_W{1'b1}}))
        r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
      if (w_ld && w_gnt1 && (r_gnt_cnt1 != {CNT_W{1'b1}}))
        r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
    end
  end

  assign bus.gnt_cnt0 = r_gnt_cnt0;
  assign bus.gnt_cnt1 = r_gnt_cnt1;
`else
  assign bus.gnt_cnt0 = {CNT_W{1'b0}};
  assign bus.gnt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Self-checking bench for alu_rr_arbiter: directed scenarios
//               followed by randomized traffic, all compared against a
//               cycle-level behavioural model of the arbitration rules.
//               Honours ALU_ARB_STATS_EN for the expected counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

  localparam int c_data_w  = 32;
  localparam int c_op_w    = 2;
  localparam int c_cnt_w   = 2;
  localparam int c_cnt_max = (1 << c_cnt_w) - 1;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  // Behavioural model state
  bit          m_v;
  logic [31:0] m_d1, m_d2;
  logic [1:0]  m_op;
  int          m_tag;
  int          m_last;
  int          m_cnt0, m_cnt1;
  bit          m_acc0, m_acc1;

  alu_rr_arbiter_if #(.DATA_W(c_data_w), .OP_W(c_op_w), .CNT_W(c_cnt_w)) bus ();

  alu_rr_arbiter #(.DATA_W(c_data_w), .OP_W(c_op_w), .CNT_W(c_cnt_w)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-robin choice: -1 none, otherwise requester index.
  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0)       return 0;
    if (v1)       return 1;
    return -1;
  endfunction

  function automatic int expected_cnt(input int c);
`ifdef ALU_ARB_STATS_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  // One clock: check handshake before the edge, advance model, check outputs.
  task automatic step();
    int w;
    bit ld;
    #1;
    ld = !m_v || !bus.stall_i;
    w  = pick(bus.v_i0, bus.v_i1, m_last);
    check_val("stall_o0", bus.stall_o0, (rst || !(ld && w == 0)) ? 1 : 0);
    check_val("stall_o1", bus.stall_o1, (rst || !(ld && w == 1)) ? 1 : 0);
    m_acc0 = !rst && ld && (w == 0);
    m_acc1 = !rst && ld && (w == 1);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_d1 = 0; m_d2 = 0; m_op = 0; m_tag = 0; m_last = 1;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_v    = 1;
        m_d1   = (w == 1) ? bus.a_i1  : bus.a_i0;
        m_d2   = (w == 1) ? bus.b_i1  : bus.b_i0;
        m_op   = (w == 1) ? bus.op_i1 : bus.op_i0;
        m_tag  = w;
        m_last = w;
        if (w == 0 && m_cnt0 < c_cnt_max) m_cnt0++;
        if (w == 1 && m_cnt1 < c_cnt_max) m_cnt1++;
      end else begin
        m_v = 0;
      end
    end
    #1;
    check_val("v_o",      bus.v_o,      m_v);
    check_val("data_o1",  bus.data_o1,  m_d1);
    check_val("data_o2",  bus.data_o2,  m_d2);
    check_val("opcode_o", bus.opcode_o, m_op);
    check_val("tag_o",    bus.tag_o,    m_tag);
    check_val("gnt_cnt0", bus.gnt_cnt0, expected_cnt(m_cnt0));
    check_val("gnt_cnt1", bus.gnt_cnt1, expected_cnt(m_cnt1));
    @(negedge clk);
  endtask

  task automatic set_req0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.v_i0 = v; bus.a_i0 = a; bus.b_i0 = b; bus.op_i0 = op;
  endtask

  task automatic set_req1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bus.v_i1 = v; bus.a_i1 = a; bus.b_i1 = b; bus.op_i1 = op;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_v = 0; m_d1 = 0; m_d2 = 0; m_op = 0; m_tag = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0;
    rst = 1;
    set_req0(0, 0, 0, 0);
    set_req1(0, 0, 0, 0);
    bus.stall_i = 0;
    @(negedge clk);
    step();
    step();
    check_val("rst_v_o", bus.v_o, 0);
    check_val("rst_tag", bus.tag_o, 0);

    // 1: single requester 0
    rst = 0;
    set_req0(1, 5, 3, 0);
    #1;
    check_val("t1_stall_o0", bus.stall_o0, 0);
    step();
    check_val("t1_v_o", bus.v_o, 1);
    check_val("t1_d1", bus.data_o1, 5);
    check_val("t1_d2", bus.data_o2, 3);
    check_val("t1_tag", bus.tag_o, 0);

    // 2: both valid, alternating grants from reset
    set_req0(0, 0, 0, 0);
    do_reset();
    set_req0(1, 5, 3, 0);
    set_req1(1, 7, 2, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("t2_stall_o0", bus.stall_o0, (i % 2 == 1) ? 1 : 0);
      check_val("t2_stall_o1", bus.stall_o1, (i % 2 == 0) ? 1 : 0);
      step();
      check_val("t2_tag", bus.tag_o, i % 2);
    end

    // 3: full stage stalled, both requesters held, then tag 1 follows
    step();
    check_val("t3_tag0", bus.tag_o, 0);
    bus.stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t3_hold_s0", bus.stall_o0, 1);
      check_val("t3_hold_s1", bus.stall_o1, 1);
      step();
      check_val("t3_hold_tag", bus.tag_o, 0);
      check_val("t3_hold_d1", bus.data_o1, 5);
    end
    bus.stall_i = 0;
    step();
    check_val("t3_next_tag", bus.tag_o, 1);

    // 4: bubble collapse with stall_i asserted and empty stage
    set_req0(0, 0, 0, 0);
    set_req1(0, 0, 0, 0);
    step();
    check_val("t4_empty", bus.v_o, 0);
    bus.stall_i = 1;
    set_req1(1, 32'hDEAD_BEEF, 32'h1234_5678, 2);
    #1;
    check_val("t4_stall_o1", bus.stall_o1, 0);
    step();
    check_val("t4_v_o", bus.v_o, 1);
    check_val("t4_tag", bus.tag_o, 1);

    // 5: reset mid-operation
    bus.stall_i = 0;
    set_req0(1, 11, 12, 3);
    step();
    rst = 1;
    #1;
    check_val("t5_rst_s0", bus.stall_o0, 1);
    check_val("t5_rst_s1", bus.stall_o1, 1);
    step();
    check_val("t5_v_o", bus.v_o, 0);
    rst = 0;
    step();
    check_val("t5_first_tag", bus.tag_o, 0);

    // 6: counter saturation with CNT_W=2
    set_req1(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_val("t6_cnt0", bus.gnt_cnt0, expected_cnt(3));
    check_val("t6_cnt1", bus.gnt_cnt1, 0);

    // Randomized traffic; requesters hold a request until it is accepted.
    for (int i = 0; i < 400; i++) begin
      if (!bus.v_i0 || m_acc0)
        set_req0($urandom_range(0, 9) < 7, $urandom, $urandom, 2'($urandom_range(0, 3)));
      if (!bus.v_i1 || m_acc1)
        set_req1($urandom_range(0, 9) < 7, $urandom, $urandom, 2'($urandom_range(0, 3)));
      bus.stall_i = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
